// File: rtl/jtopl_csr_pkg.sv
// Operator configuration store: shared byte map.
// Offsets of the four operator bytes inside a ring slot.
package jtopl_csr_pkg;

  localparam int OPCFGW    = 32;
  localparam int MULT_MSB  = 31;
  localparam int KSLTL_MSB = 23;
  localparam int ARDR_MSB  = 15;
  localparam int SLRR_MSB  = 7;

endpackage

// File: rtl/jtopl_sh_rst.sv
// Clock-enabled shift register with sync reset to rstval.
// Ports: clk, cen, rst, din[width] in; drop[width] = last stage.
module jtopl_sh_rst #(
  parameter int               width  = 5,
  parameter int               stages = 18,
  parameter logic [width-1:0] rstval = '0
) (
  input  logic             clk,
  input  logic             cen,
  input  logic             rst,
  input  logic [width-1:0] din,
  output logic [width-1:0] drop
);

  logic [width-1:0] r_bits [stages];

  // Reset is deliberately independent of cen.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < stages; i++)
        r_bits[i] <= rstval;
    end else if (cen) begin
      r_bits[0] <= din;
      for (int i = 1; i < stages; i++)
        r_bits[i] <= r_bits[i-1];
    end
  end

  assign drop = r_bits[stages-1];

endmodule

// File: rtl/jtopl_csr.sv
// OPL operator config ring: LEN slots of MULT, KSL/TL, AR/DR, SL/RR.
// Ports: clk, rst, cen, din, up_* group selects, update_op_I/II/IV; shift_out.
module jtopl_csr
  import jtopl_csr_pkg::*;
#(
  parameter int LEN = 18,
  parameter int W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen,
  input  logic [7:0]   din,
  output logic [W-1:0] shift_out,
  input  logic         up_mult,
  input  logic         up_ksl_tl,
  input  logic         up_ar_dr,
  input  logic         up_sl_rr,
  input  logic         update_op_I,
  input  logic         update_op_II,
  input  logic         update_op_IV
);

  logic [W-1:0] w_ring_in;

  // Each field is substituted when its target operator reaches
  // the pipeline stage that consumes it; mult is split over I/II.
  always_comb begin
    w_ring_in = shift_out;
    if (up_mult & update_op_I)
      w_ring_in[MULT_MSB -: 3] = din[7:5];
    if (up_mult & update_op_II)
      w_ring_in[MULT_MSB-3 -: 5] = din[4:0];
    if (up_ksl_tl & update_op_IV)
      w_ring_in[KSLTL_MSB -: 8] = din;
    if (up_ar_dr & update_op_I)
      w_ring_in[ARDR_MSB -: 8] = din;
    if (up_sl_rr & update_op_I)
      w_ring_in[SLRR_MSB -: 8] = din;
  end

  jtopl_sh_rst #(
    .width  (W),
    .stages (LEN),
    .rstval ({W{1'b0}})
  ) u_ring (
    .clk  (clk),
    .cen  (cen),
    .rst  (rst),
    .din  (w_ring_in),
    .drop (shift_out)
  );

endmodule

// File: tb/tb_jtopl_csr.sv
// Self-checking bench for jtopl_csr and standalone jtopl_sh_rst.
// Table of single writes plus directed multi-cycle sequences.
module tb_jtopl_csr;

  logic        clk = 1'b0;
  logic        rst, cen;
  logic [7:0]  din;
  logic [31:0] shift_out;
  logic        up_mult, up_ksl_tl, up_ar_dr, up_sl_rr;
  logic        op_I, op_II, op_IV;

  logic        s_cen, s_rst;
  logic [17:0] s_din, s_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtopl_csr dut (
    .clk          (clk),
    .rst          (rst),
    .cen          (cen),
    .din          (din),
    .shift_out    (shift_out),
    .up_mult      (up_mult),
    .up_ksl_tl    (up_ksl_tl),
    .up_ar_dr     (up_ar_dr),
    .up_sl_rr     (up_sl_rr),
    .update_op_I  (op_I),
    .update_op_II (op_II),
    .update_op_IV (op_IV)
  );

  jtopl_sh_rst #(
    .width  (18),
    .stages (3),
    .rstval (18'd0)
  ) u_sh (
    .clk  (clk),
    .cen  (s_cen),
    .rst  (s_rst),
    .din  (s_din),
    .drop (s_drop)
  );

  // up = {mult, ksl_tl, ar_dr, sl_rr}, op = {I, II, IV}
  typedef struct {
    logic [7:0]  din;
    logic [3:0]  up;
    logic [2:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic set_wr(logic [7:0] d, logic [3:0] up, logic [2:0] op);
    din       = d;
    up_mult   = up[3];
    up_ksl_tl = up[2];
    up_ar_dr  = up[1];
    up_sl_rr  = up[0];
    op_I      = op[2];
    op_II     = op[1];
    op_IV     = op[0];
  endtask

  task automatic clr_wr();
    set_wr(8'h00, 4'b0000, 3'b000);
  endtask

  task automatic do_reset();
    clr_wr();
    rst = 1'b1;
    cen = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // n cen edges with no write
  task automatic run(int n);
    clr_wr();
    cen = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b0; cen = 1'b0;
    s_cen = 1'b0; s_rst = 1'b0; s_din = '0;
    clr_wr();

    vecs[0] = '{8'hA5, 4'b0010, 3'b100, 32'h0000A500};
    vecs[1] = '{8'hFF, 4'b1000, 3'b100, 32'hE0000000};
    vecs[2] = '{8'hFF, 4'b1000, 3'b010, 32'h1F000000};
    vecs[3] = '{8'hC3, 4'b0100, 3'b100, 32'h00000000};
    vecs[4] = '{8'hC3, 4'b0100, 3'b001, 32'h00C30000};
    vecs[5] = '{8'h5A, 4'b0001, 3'b100, 32'h0000005A};
    vecs[6] = '{8'h5A, 4'b0001, 3'b010, 32'h00000000};
    vecs[7] = '{8'h3C, 4'b1111, 3'b100, 32'h20003C3C};
    vecs[8] = '{8'h81, 4'b0010, 3'b011, 32'h00000000};

    do_reset();
    chk("reset", shift_out, 32'h0);

    // write on edge 1; visible on edge 18 and again on 36
    for (int v = 0; v < 9; v++) begin
      do_reset();
      cen = 1'b1;
      set_wr(vecs[v].din, vecs[v].up, vecs[v].op);
      tick();
      run(16);
      chk($sformatf("v%0d_e17", v), shift_out, 32'h0);
      run(1);
      chk($sformatf("v%0d_e18", v), shift_out, vecs[v].exp);
      run(1);
      chk($sformatf("v%0d_e19", v), shift_out, 32'h0);
      run(17);
      chk($sformatf("v%0d_e36", v), shift_out, vecs[v].exp);
    end

    // mult: I on one slot, II on the next slot
    do_reset();
    cen = 1'b1;
    set_wr(8'hFF, 4'b1000, 3'b100); tick();
    set_wr(8'hFF, 4'b1000, 3'b010); tick();
    run(16);
    chk("mult_succ_e18", shift_out, 32'hE0000000);
    run(1);
    chk("mult_succ_e19", shift_out, 32'h1F000000);

    // mult: I then II on the same operator one lap later
    do_reset();
    cen = 1'b1;
    set_wr(8'hFF, 4'b1000, 3'b100); tick();
    run(17);
    chk("mult_lap_e18", shift_out, 32'hE0000000);
    set_wr(8'hFF, 4'b1000, 3'b010); tick();
    run(17);
    chk("mult_lap_e36", shift_out, 32'hFF000000);

    // reset with cen=0 on nonzero output, then 36 pulses of zero
    do_reset();
    cen = 1'b1;
    set_wr(8'hA5, 4'b0010, 3'b100); tick();
    run(17);
    chk("pre_rst", shift_out, 32'h0000A500);
    clr_wr();
    cen = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_nocen", shift_out, 32'h0);
    begin
      logic [31:0] acc;
      acc = '0;
      for (int i = 0; i < 36; i++) begin
        run(1);
        acc |= shift_out;
      end
      chk("rst_36", acc, 32'h0);
    end

    // reset overrides a simultaneous write
    do_reset();
    cen = 1'b1;
    rst = 1'b1;
    set_wr(8'hA5, 4'b0010, 3'b100); tick();
    rst = 1'b0;
    run(17);
    chk("rst_ovr_e18", shift_out, 32'h0);

    // cen gating: freeze after 10 edges, resume, value on edge 18
    do_reset();
    cen = 1'b1;
    set_wr(8'h77, 4'b0001, 3'b100); tick();
    run(9);
    clr_wr();
    cen = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    chk("frz_mid", shift_out, 32'h0);
    run(7);
    chk("frz_e17", shift_out, 32'h0);
    run(1);
    chk("frz_e18", shift_out, 32'h00000077);
    cen = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    chk("frz_hold", shift_out, 32'h00000077);
    run(1);
    chk("frz_e19", shift_out, 32'h0);

    // standalone shifter, 3 stages
    s_rst = 1'b1; tick(); s_rst = 1'b0;
    chk("sh_rst", {14'd0, s_drop}, 32'h0);
    s_cen = 1'b1; s_din = 18'h3FFFF; tick();
    s_din = '0;
    chk("sh_e1", {14'd0, s_drop}, 32'h0);
    tick();
    chk("sh_e2", {14'd0, s_drop}, 32'h0);
    tick();
    chk("sh_e3", {14'd0, s_drop}, 32'h3FFFF);
    tick();
    chk("sh_e4", {14'd0, s_drop}, 32'h0);
    s_din = 18'h3FFFF; tick();
    s_din = '0; tick();
    s_cen = 1'b0; s_rst = 1'b1; tick();
    s_rst = 1'b0;
    s_cen = 1'b1; tick();
    chk("sh_midrst", {14'd0, s_drop}, 32'h0);
    s_cen = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
